// File: rtl/operand_demux_pkg.sv
// Shared definitions for operand_stream_demux: FSM state encoding and the
// command word field layout (N_ROW in the low half, N_COL in the high half).
package operand_demux_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INSTR = 3'd1,
    COLS  = 3'd2,
    ROWS  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int unsigned ROW_LSB = 0;
  localparam int unsigned COL_LSB = 16;
  localparam int unsigned FIELD_W = 16;

endpackage

// File: rtl/st_pipe_reg.sv
// One-entry ready/valid pipeline register.
//   clk, rst_n             : clock, async active-low reset
//   load_valid, load_data  : beat to capture (caller only loads when load_ready)
//   load_ready             : register can take a beat this cycle
//   out_valid, out_data    : registered output stream
//   out_ready              : downstream ready
module st_pipe_reg #(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Free when empty or when the held beat leaves this cycle.
  assign load_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_valid && load_ready) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/operand_stream_demux.sv
// Splits one operand stream into column and row sink streams for the
// systolic array, issuing one instruction word per job.
//   clock_sink, reset_sink_reset_n : clock, async active-low reset
//   cmd_*      : job command in ([31:16] N_COL, [15:0] N_ROW)
//   in_*       : operand beats (N_COL column beats then N_ROW row beats)
//   st_instr_* : instruction word out (the latched command)
//   st_cols_*  : column beats out
//   st_rows_*  : row beats out
//   busy       : not IDLE
//   job_done   : one-cycle pulse once all beats of a job have drained
module operand_stream_demux
  import operand_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CMD_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock_sink,
  input  logic              reset_sink_reset_n,
  input  logic [CMD_W-1:0]  cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CMD_W-1:0]  st_instr_data,
  output logic              st_instr_valid,
  input  logic              st_instr_ready,
  output logic [DATA_W-1:0] st_cols_data,
  output logic              st_cols_valid,
  input  logic              st_cols_ready,
  output logic [DATA_W-1:0] st_rows_data,
  output logic              st_rows_valid,
  input  logic              st_rows_ready,
  output logic              busy,
  output logic              job_done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CMD_W-1:0]   instr_data_q, instr_data_d;
  logic               instr_valid_q, instr_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               job_done_q, job_done_d;

  logic               cols_load, rows_load;
  logic               cols_load_ready, rows_load_ready;
  logic               in_ready_c;

  always_comb begin
    state_d       = state_q;
    col_cnt_d     = col_cnt_q;
    row_cnt_d     = row_cnt_q;
    instr_data_d  = instr_data_q;
    instr_valid_d = instr_valid_q;
    job_done_d    = 1'b0;
    in_ready_c    = 1'b0;
    cols_load     = 1'b0;
    rows_load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          row_cnt_d     = cmd_data[ROW_LSB +: FIELD_W];
          col_cnt_d     = cmd_data[COL_LSB +: FIELD_W];
          instr_data_d  = cmd_data;
          instr_valid_d = 1'b1;
          state_d       = INSTR;
        end
      end
      INSTR: begin
        if (instr_valid_q && st_instr_ready) begin
          instr_valid_d = 1'b0;
          if (col_cnt_q != '0)      state_d = COLS;
          else if (row_cnt_q != '0) state_d = ROWS;
          else                      state_d = DRAIN;
        end
      end
      COLS: begin
        in_ready_c = cols_load_ready;
        if (in_valid && cols_load_ready) begin
          cols_load = 1'b1;
          col_cnt_d = col_cnt_q - 1'b1;
          if (col_cnt_q == CNT_W'(1))
            state_d = (row_cnt_q != '0) ? ROWS : DRAIN;
        end
      end
      ROWS: begin
        in_ready_c = rows_load_ready;
        if (in_valid && rows_load_ready) begin
          rows_load = 1'b1;
          row_cnt_d = row_cnt_q - 1'b1;
          if (row_cnt_q == CNT_W'(1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!st_cols_valid && !st_rows_valid) begin
          job_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q       <= IDLE;
      col_cnt_q     <= '0;
      row_cnt_q     <= '0;
      instr_data_q  <= '0;
      instr_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      job_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      row_cnt_q     <= row_cnt_d;
      instr_data_q  <= instr_data_d;
      instr_valid_q <= instr_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      job_done_q    <= job_done_d;
    end
  end

  st_pipe_reg #(.DATA_W(DATA_W)) u_cols (
    .clk        (clock_sink),
    .rst_n      (reset_sink_reset_n),
    .load_valid (cols_load),
    .load_data  (in_data),
    .load_ready (cols_load_ready),
    .out_valid  (st_cols_valid),
    .out_data   (st_cols_data),
    .out_ready  (st_cols_ready)
  );

  st_pipe_reg #(.DATA_W(DATA_W)) u_rows (
    .clk        (clock_sink),
    .rst_n      (reset_sink_reset_n),
    .load_valid (rows_load),
    .load_data  (in_data),
    .load_ready (rows_load_ready),
    .out_valid  (st_rows_valid),
    .out_data   (st_rows_data),
    .out_ready  (st_rows_ready)
  );

  assign cmd_ready      = cmd_ready_q;
  assign in_ready       = in_ready_c;
  assign st_instr_data  = instr_data_q;
  assign st_instr_valid = instr_valid_q;
  assign busy           = (state_q != IDLE);
  assign job_done       = job_done_q;

endmodule
